dl_therm_decoder: RTL and testbench

Downstream stage of the carry-chain delay-line tester. Takes the registered LENGTH-bit delay-line snapshot every clock, bubble-corrects it, and converts the thermometer pattern to a binary delay code. It also tracks min/max code and a saturating sample count over a software-cleared window. Output feeds calibration and histogram logic.

---
 rtl/dl_pkg.sv | 31 +++
 rtl/dl_popcount.sv | 25 ++
 rtl/dl_therm_decoder.sv | 168 ++++++++++++++++
 tb/tb_dl_therm_decoder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/dl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dl_pkg
// Description : Shared helpers for the delay-line thermometer decoder.
//               Code-width function, statistics reset constants and the
//               3-input majority used for bubble correction.
// Revision    : 1.0 - initial release
// ============================================================================
package dl_pkg;

    // Maximum statistic value is reset to the smallest possible code.
    localparam int c_MAX_CODE_RST = 0;

    // Width needed to hold a zero count in the range 0..length.
    function automatic int code_width(input int length);
        return $clog2(length + 1);
    endfunction

    // Minimum statistic is reset to the largest possible code so that the
    // first sample of a window always replaces it.
    function automatic int min_code_reset(input int length);
        return length;
    endfunction

    // Majority of three neighbouring taps; removes isolated single-bit bubbles.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage : dl_pkg
`default_nettype wire

// File: rtl/dl_popcount.sv
`default_nettype none
// ============================================================================
// Module      : dl_popcount
// Description : Combinational population count of a LENGTH-bit word.
//               Ports: i_word  [LENGTH-1:0] word to count
//                      o_count [CW-1:0]     number of set bits (0..LENGTH)
// Revision    : 1.0 - initial release
// ============================================================================
module dl_popcount #(
    parameter int LENGTH = 16,
    parameter int CW     = $clog2(LENGTH + 1)
) (
    input  logic [LENGTH-1:0] i_word,
    output logic [CW-1:0]     o_count
);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < LENGTH; i++) begin
            o_count = o_count + CW'(i_word[i]);
        end
    end

endmodule : dl_popcount
`default_nettype wire

// File: rtl/dl_therm_decoder.sv
`default_nettype none
// ============================================================================
// Module      : dl_therm_decoder
// Description : Carry-chain delay-line thermometer decoder.
//               S1 resyncs the captured word, S2 bubble-corrects it, S3 turns
//               the number of cleared taps into a binary delay code. A
//               statistics block tracks min/max code and a saturating sample
//               count over a window restarted by 'clear'.
//               Optional feature macro: DL_BUBBLE_CORR_EN (majority bubble
//               correction in S2; when undefined S2 passes the raw word and
//               bubble_err stays 0).
// Ports       : clk        delay-line clock, all logic on rising edge
//               rst_n      synchronous active-low reset
//               din        captured delay-line word (bit 0 = chain start)
//               din_valid  din qualifies this cycle
//               clear      start a new statistics window
//               code_out   decoded delay code (holds when not valid)
//               code_valid one-cycle pulse per accepted din, 3 cycles later
//               bubble_err correction changed the word (with code_valid)
//               min_code   smallest code in window
//               max_code   largest code in window
//               sample_cnt codes in window, saturating
// Revision    : 1.0 - initial release
// ============================================================================
module dl_therm_decoder
    import dl_pkg::*;
#(
    parameter  int LENGTH = 16,
    parameter  int CNT_W  = 16,
    localparam int CW     = code_width(LENGTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LENGTH-1:0] din,
    input  logic              din_valid,
    input  logic              clear,
    output logic [CW-1:0]     code_out,
    output logic              code_valid,
    output logic              bubble_err,
    output logic [CW-1:0]     min_code,
    output logic [CW-1:0]     max_code,
    output logic [CNT_W-1:0]  sample_cnt
);

    localparam logic [CW-1:0] c_LEN_CODE = CW'(LENGTH);
    localparam logic [CW-1:0] c_MIN_RST  = CW'(min_code_reset(LENGTH));
    localparam logic [CW-1:0] c_MAX_RST  = CW'(c_MAX_CODE_RST);

    // ------------------------------------------------------------------
    // S1: resync flop
    // ------------------------------------------------------------------
    logic [LENGTH-1:0] r_s1_din;
    logic              r_s1_vld;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_din <= '1;
            r_s1_vld <= 1'b0;
        end else begin
            r_s1_din <= din;
            r_s1_vld <= din_valid;
        end
    end

    // ------------------------------------------------------------------
    // S2: bubble correction
    // ------------------------------------------------------------------
    logic [LENGTH-1:0] w_s2_word;
    logic              w_s2_err;

`ifdef DL_BUBBLE_CORR_EN
    // Pad below with 0 (edge already passed the chain start) and above with
    // 1 (idle taps past the end), so every tap sees two neighbours.
    logic [LENGTH+1:0] w_pad;
    assign w_pad = {1'b1, r_s1_din, 1'b0};

    for (genvar gi = 0; gi < LENGTH; gi++) begin : g_bubble
        assign w_s2_word[gi] = maj3(w_pad[gi], w_pad[gi+1], w_pad[gi+2]);
    end

    assign w_s2_err = (w_s2_word != r_s1_din);
`else
    assign w_s2_word = r_s1_din;
    assign w_s2_err  = 1'b0;
`endif

    logic [LENGTH-1:0] r_s2_word;
    logic              r_s2_vld;
    logic              r_s2_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_word <= '1;
            r_s2_vld  <= 1'b0;
            r_s2_err  <= 1'b0;
        end else begin
            r_s2_word <= w_s2_word;
            r_s2_vld  <= r_s1_vld;
            r_s2_err  <= w_s2_err;
        end
    end

    // ------------------------------------------------------------------
    // S3: code = number of cleared taps
    // ------------------------------------------------------------------
    logic [CW-1:0] w_ones;
    logic [CW-1:0] w_s3_code;

    dl_popcount #(
        .LENGTH (LENGTH),
        .CW     (CW)
    ) u_popcount (
        .i_word  (r_s2_word),
        .o_count (w_ones)
    );

    assign w_s3_code = c_LEN_CODE - w_ones;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            code_out   <= '0;
            code_valid <= 1'b0;
            bubble_err <= 1'b0;
        end else begin
            code_valid <= r_s2_vld;
            bubble_err <= r_s2_vld & r_s2_err;
            // Code holds its last value across invalid cycles.
            if (r_s2_vld) begin
                code_out <= w_s3_code;
            end
        end
    end

    // ------------------------------------------------------------------
    // Window statistics, one cycle behind code_valid
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            min_code   <= c_MIN_RST;
            max_code   <= c_MAX_RST;
            sample_cnt <= '0;
        end else if (clear) begin
            // A code arriving with clear becomes the first sample of the
            // new window rather than being dropped.
            if (code_valid) begin
                min_code   <= code_out;
                max_code   <= code_out;
                sample_cnt <= CNT_W'(1);
            end else begin
                min_code   <= c_MIN_RST;
                max_code   <= c_MAX_RST;
                sample_cnt <= '0;
            end
        end else if (code_valid) begin
            if (code_out < min_code) begin
                min_code <= code_out;
            end
            if (code_out > max_code) begin
                max_code <= code_out;
            end
            if (sample_cnt != '1) begin
                sample_cnt <= sample_cnt + CNT_W'(1);
            end
        end
    end

endmodule : dl_therm_decoder
`default_nettype wire

// File: tb/tb_dl_therm_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dl_therm_decoder
// Description : Directed self-checking bench for dl_therm_decoder. A second
//               instance with a 4-bit sample counter shares the stimulus to
//               exercise counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dl_therm_decoder;

    localparam int c_LEN = 16;
    localparam int c_CW  = 5;

    logic              clk;
    logic              rst_n;
    logic [c_LEN-1:0]  din;
    logic              din_valid;
    logic              clear;

    logic [c_CW-1:0]   code_out;
    logic              code_valid;
    logic              bubble_err;
    logic [c_CW-1:0]   min_code;
    logic [c_CW-1:0]   max_code;
    logic [15:0]       sample_cnt;

    logic [c_CW-1:0]   code_out4;
    logic              code_valid4;
    logic              bubble_err4;
    logic [c_CW-1:0]   min_code4;
    logic [c_CW-1:0]   max_code4;
    logic [3:0]        sample_cnt4;

    int n_checks;
    int n_pass;

    dl_therm_decoder #(
        .LENGTH (c_LEN),
        .CNT_W  (16)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .clear      (clear),
        .code_out   (code_out),
        .code_valid (code_valid),
        .bubble_err (bubble_err),
        .min_code   (min_code),
        .max_code   (max_code),
        .sample_cnt (sample_cnt)
    );

    dl_therm_decoder #(
        .LENGTH (c_LEN),
        .CNT_W  (4)
    ) u_dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .clear      (clear),
        .code_out   (code_out4),
        .code_valid (code_valid4),
        .bubble_err (bubble_err4),
        .min_code   (min_code4),
        .max_code   (max_code4),
        .sample_cnt (sample_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: inputs set before the edge, outputs sampled 1 ns after.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [c_LEN-1:0] d, input logic v);
        din       = d;
        din_valid = v;
        step();
    endtask

    logic [31:0] exp_ff04_code;
    logic [31:0] exp_ff04_err;

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        clear     = 1'b0;
        din       = 16'hFFF0;
        din_valid = 1'b1;
`ifdef DL_BUBBLE_CORR_EN
        exp_ff04_code = 32'd8;
        exp_ff04_err  = 32'd1;
`else
        exp_ff04_code = 32'd7;
        exp_ff04_err  = 32'd0;
`endif

        // Reset held 3 cycles with valid input present.
        step(); step(); step();
        chk("rst_code",  32'(code_out),   32'd0);
        chk("rst_valid", 32'(code_valid), 32'd0);
        chk("rst_err",   32'(bubble_err), 32'd0);
        chk("rst_min",   32'(min_code),   32'd16);
        chk("rst_max",   32'(max_code),   32'd0);
        chk("rst_cnt",   32'(sample_cnt), 32'd0);

        // Release, then clear with nothing in flight.
        rst_n = 1'b1;
        clear = 1'b1;
        drive(16'hFFFF, 1'b0);
        chk("idle_valid", 32'(code_valid), 32'd0);
        clear = 1'b0;

        // Window: FFFF, FFF0, FF00 -> codes 0, 4, 8.
        drive(16'hFFFF, 1'b1);
        drive(16'hFFF0, 1'b1);
        chk("lat2_valid", 32'(code_valid), 32'd0);
        drive(16'hFF00, 1'b1);
        chk("c0_valid", 32'(code_valid), 32'd1);
        chk("c0_code",  32'(code_out),   32'd0);
        chk("c0_err",   32'(bubble_err), 32'd0);
        drive(16'hFFFF, 1'b0);
        chk("c4_valid", 32'(code_valid), 32'd1);
        chk("c4_code",  32'(code_out),   32'd4);
        chk("c4_err",   32'(bubble_err), 32'd0);
        drive(16'hFFFF, 1'b0);
        chk("c8_code",  32'(code_out),   32'd8);
        chk("w2_min",   32'(min_code),   32'd0);
        chk("w2_max",   32'(max_code),   32'd4);
        chk("w2_cnt",   32'(sample_cnt), 32'd2);
        drive(16'hFFFF, 1'b0);
        chk("hold_valid", 32'(code_valid), 32'd0);
        chk("hold_code",  32'(code_out),   32'd8);
        chk("w3_min",     32'(min_code),   32'd0);
        chk("w3_max",     32'(max_code),   32'd8);
        chk("w3_cnt",     32'(sample_cnt), 32'd3);

        // Clear coincident with code 4.
        drive(16'hFFF0, 1'b1);
        drive(16'hFFFF, 1'b0);
        drive(16'hFFFF, 1'b0);
        chk("cc_valid", 32'(code_valid), 32'd1);
        clear = 1'b1;
        drive(16'hFFFF, 1'b0);
        clear = 1'b0;
        chk("cc_min", 32'(min_code),   32'd4);
        chk("cc_max", 32'(max_code),   32'd4);
        chk("cc_cnt", 32'(sample_cnt), 32'd1);

        // Isolated one at bit 2.
        drive(16'hFF04, 1'b1);
        drive(16'hFFFF, 1'b0);
        drive(16'hFFFF, 1'b0);
        chk("bub_valid", 32'(code_valid), 32'd1);
        chk("bub_code",  32'(code_out),   exp_ff04_code);
        chk("bub_err",   32'(bubble_err), exp_ff04_err);
        drive(16'hFFFF, 1'b0);
        chk("bub_err_clr", 32'(bubble_err), 32'd0);

        // Saturation: 20 consecutive valid codes.
        clear = 1'b1;
        drive(16'hFFFF, 1'b0);
        clear = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive(16'hFFFF, 1'b1);
        end
        for (int i = 0; i < 4; i++) begin
            drive(16'hFFFF, 1'b0);
        end
        chk("sat_cnt4",  32'(sample_cnt4), 32'd15);
        chk("sat_cnt16", 32'(sample_cnt),  32'd20);
        chk("sat_code4", 32'(code_out4),   32'd0);

        // Every-other-cycle stream with a 1-cycle reset mid-flight.
        drive(16'hFFF0, 1'b1);
        drive(16'hFFFF, 1'b0);
        drive(16'hFF00, 1'b1);
        chk("pulse_valid", 32'(code_valid), 32'd1);
        chk("pulse_code",  32'(code_out),   32'd4);
        rst_n = 1'b0;
        drive(16'hFFFF, 1'b0);
        rst_n = 1'b1;
        chk("mr_valid", 32'(code_valid), 32'd0);
        chk("mr_code",  32'(code_out),   32'd0);
        chk("mr_min",   32'(min_code),   32'd16);
        chk("mr_max",   32'(max_code),   32'd0);
        chk("mr_cnt",   32'(sample_cnt), 32'd0);
        drive(16'hFFFF, 1'b0);
        chk("mr_lost", 32'(code_valid), 32'd0);
        drive(16'hF000, 1'b1);
        drive(16'hFFFF, 1'b0);
        chk("post_lat2", 32'(code_valid), 32'd0);
        drive(16'hFFFF, 1'b0);
        chk("post_valid", 32'(code_valid), 32'd1);
        chk("post_code",  32'(code_out),   32'd12);
        drive(16'hFFFF, 1'b0);
        chk("post_min", 32'(min_code),   32'd12);
        chk("post_max", 32'(max_code),   32'd12);
        chk("post_cnt", 32'(sample_cnt), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_dl_therm_decoder
`default_nettype wire
